// File: rtl/fifo_read_ctrl.sv
// Drain stage behind the FIFO controller/RAM: pops words into a 2-entry buffer and
// presents them as a framed valid/ready stream with m_last every FRAME_LEN beats.
module fifo_read_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FRAME_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    output logic                  fifo_rd,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  frame_cnt,
    output logic                  busy
);

    localparam int unsigned BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

    logic                  r_started;
    logic [1:0]            r_buf_cnt;
    logic                  r_inflight;
    logic                  r_head;
    logic [DATA_WIDTH-1:0] r_buf [2];
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_tail;
    logic [1:0]            w_buf_next;

    // The pop is decided in the same clock it is issued, so head + in-flight + new pop
    // always fit the two buffer entries while still allowing one word per clock.
    always_comb begin
        w_pop      = (r_buf_cnt != 2'd0) & m_ready;
        w_buf_next = r_buf_cnt + 2'(r_inflight) - 2'(w_pop);
        w_issue    = r_started & en & ~fifo_empty & (w_buf_next < 2'd2);
        w_tail     = r_head ^ r_buf_cnt[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started   <= 1'b0;
            r_buf_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_head      <= 1'b0;
            r_buf[0]    <= '0;
            r_buf[1]    <= '0;
            r_beat_cnt  <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_started  <= 1'b1;
            r_inflight <= w_issue;
            r_buf_cnt  <= w_buf_next;
            if (r_inflight) begin
                r_buf[w_tail] <= fifo_rdata;
            end
            if (w_pop) begin
                r_head <= ~r_head;
                if (r_beat_cnt == LAST_BEAT) begin
                    r_beat_cnt  <= '0;
                    r_frame_cnt <= r_frame_cnt + CNT_WIDTH'(1);
                end else begin
                    r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        fifo_rd   = w_issue;
        m_valid   = (r_buf_cnt != 2'd0);
        m_data    = r_buf[r_head];
        m_last    = (r_buf_cnt != 2'd0) & (r_beat_cnt == LAST_BEAT);
        frame_cnt = r_frame_cnt;
        busy      = (r_buf_cnt != 2'd0) | r_inflight;
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: FIFO environment model, pop-order scoreboard with 2-clk
// visibility rule, per-cycle output compare, and directed scenarios with literal results.
module tb_fifo_read_ctrl;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          m_ready = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd, m_valid, m_last, busy;
    logic [DW-1:0] m_data;
    logic [CW-1:0] frame_cnt;

    logic          f1_rd, f1_valid, f1_last, f1_busy;
    logic [DW-1:0] f1_data;
    logic [CW-1:0] f1_frames;

    fifo_read_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) u_dut (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .frame_cnt(frame_cnt), .busy(busy)
    );

    // Single-beat frames: only its m_last/m_valid relation is checked.
    fifo_read_ctrl #(.DATA_WIDTH(DW), .FRAME_LEN(1), .CNT_WIDTH(CW)) u_dut_f1 (
        .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_rd(f1_rd),
        .fifo_rdata(fifo_rdata), .m_valid(f1_valid), .m_ready(m_ready), .m_data(f1_data),
        .m_last(f1_last), .frame_cnt(f1_frames), .busy(f1_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int unsigned   cyc;
    } ent_t;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] wr_pend[$];
    ent_t          sb[$];
    int unsigned   cyc = 0;
    int unsigned   beats = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model_d;

    int unsigned   pop_cycs[$];
    int unsigned   beat_cycs[$];
    logic [DW-1:0] obs_data[$];
    logic [DW-1:0] obs_last[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // A popped word becomes visible two clocks after its pop cycle, in pop order.
    function automatic bit model_valid();
        return (sb.size() > 0) && (sb[0].cyc + 2 <= cyc);
    endfunction

    // FIFO environment and scoreboard bookkeeping on the active edge.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
            beats = 0;
        end else begin
            if (model_valid() && m_ready) begin
                void'(sb.pop_front());
                beats++;
            end
            if (fifo_rd && fifo_q.size() > 0) begin
                model_d = fifo_q.pop_front();
                sb.push_back('{data: model_d, cyc: cyc});
                fifo_rdata <= model_d;
            end else begin
                fifo_rdata <= DW'($urandom);
            end
        end
        while (wr_pend.size() > 0) fifo_q.push_back(wr_pend.pop_front());
        fifo_empty <= (fifo_q.size() == 0);
        cyc++;
    end

    // Per-cycle compare against the model, plus observation logs for directed checks.
    always @(negedge clk) begin
        if (!rst) begin
            bit ev;
            ev = model_valid();
            check("m_valid", m_valid, ev);
            check("busy", busy, sb.size() != 0);
            check("m_last", m_last, ev && (beats % FL == FL - 1));
            if (ev) check("m_data", m_data, sb[0].data);
            check("frame_cnt", frame_cnt, (beats / FL) % 65536);
            if (fifo_rd) check("rd_while_empty", fifo_empty, 0);
            check("rd_while_en0", fifo_rd & ~en, 0);
            check("outstanding_le2", sb.size() <= 2, 1);
            check("f1_last", f1_last, f1_valid);
            if (fifo_rd) pop_cycs.push_back(cyc);
            if (m_valid && m_ready) begin
                beat_cycs.push_back(cyc);
                obs_data.push_back(m_data);
                if (m_last) obs_last.push_back(m_data);
            end
        end
    end

    task automatic push(input logic [DW-1:0] d);
        wr_pend.push_back(d);
    endtask

    task automatic clear_obs();
        pop_cycs.delete();
        beat_cycs.delete();
        obs_data.delete();
        obs_last.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while (!(fifo_q.size() == 0 && wr_pend.size() == 0 && sb.size() == 0 && !busy)
               && n < max_cyc) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, (fifo_q.size() == 0 && sb.size() == 0 && !busy), 1);
        tick();
    endtask

    task automatic wait_pops(input int unsigned n, input int max_cyc, input string tag);
        int k = 0;
        while (pop_cycs.size() < n && k < max_cyc) begin
            tick();
            k++;
        end
        check({tag, "_pop_seen"}, pop_cycs.size() >= n, 1);
    endtask

    initial begin
        logic [DW-1:0] dcnt;
        int unsigned   npush;

        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        en = 1'b1;
        m_ready = 1'b1;

        // 1: eight words, sink always ready
        clear_obs();
        for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
        wait_idle(40, "t1");
        check("t1_beats", beat_cycs.size(), 8);
        check("t1_back_to_back", beat_cycs[7] - beat_cycs[0], 7);
        check("t1_lasts", obs_last.size(), 2);
        check("t1_last0", obs_last[0], 8'h13);
        check("t1_last1", obs_last[1], 8'h17);
        check("t1_frames", frame_cnt, 2);

        // 2: sink stalled, buffer fills after two pops
        clear_obs();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(DW'(8'h20 + i));
        repeat (10) tick();
        check("t2_pops", pop_cycs.size(), 2);
        check("t2_rd_low", fifo_rd, 0);
        check("t2_valid", m_valid, 1);
        check("t2_head", m_data, 8'h20);
        m_ready = 1'b1;
        wait_idle(40, "t2");
        check("t2_beats", obs_data.size(), 6);
        check("t2_tail", obs_data[5], 8'h25);

        // 3: single word
        clear_obs();
        push(8'h30);
        wait_idle(20, "t3");
        check("t3_pops", pop_cycs.size(), 1);
        check("t3_beats", beat_cycs.size(), 1);
        check("t3_latency", beat_cycs[0] - pop_cycs[0], 2);
        check("t3_data", obs_data[0], 8'h30);

        // 4: en dropped right after a pop; 15 beats so far so 0x40 closes a frame
        clear_obs();
        for (int i = 0; i < 4; i++) push(DW'(8'h40 + i));
        wait_pops(1, 20, "t4");
        en = 1'b0;
        repeat (8) tick();
        check("t4_pops_en0", pop_cycs.size(), 1);
        check("t4_delivered", obs_data.size(), 1);
        check("t4_inflight_data", obs_data[0], 8'h40);
        check("t4_last_kept", obs_last.size(), 1);
        check("t4_frames", frame_cnt, 4);
        check("t4_busy", busy, 0);
        en = 1'b1;
        wait_idle(30, "t4");
        check("t4_beats", obs_data.size(), 4);
        check("t4_no_new_last", obs_last.size(), 1);
        check("t4_frames_end", frame_cnt, 4);

        // 5: reset with one word buffered and one in flight
        clear_obs();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(DW'(8'h50 + i));
        wait_pops(2, 20, "t5");
        check("t5_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_fifo_rd", fifo_rd, 0);
        check("t5_m_valid", m_valid, 0);
        check("t5_m_data", m_data, 0);
        check("t5_m_last", m_last, 0);
        check("t5_frame_cnt", frame_cnt, 0);
        check("t5_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b1;
        wait_idle(30, "t5");
        check("t5_beats", obs_data.size(), 3);
        check("t5_first", obs_data[0], 8'h52);
        check("t5_frames", frame_cnt, 0);

        // 6: random writes and sink stalls
        clear_obs();
        dcnt = 8'h00;
        npush = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            m_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                push(dcnt);
                dcnt++;
                npush++;
            end
        end
        m_ready = 1'b1;
        wait_idle(200, "t6");
        check("t6_beats", obs_data.size(), npush);
        check("t6_lasts", obs_last.size(), (3 + npush) / FL);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
